// File: rtl/if_fetch_sequencer.sv
// IF-stage control sequencer: PC/nPC/IF-ID load enables, next-address mux select and IF/ID clear.
// Optional performance counters are built when IF_SEQ_PERF_EN is defined.
module if_fetch_sequencer #(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             R,
    input  logic             hz_stall,
    input  logic             id_branch,
    input  logic             id_cond_true,
    input  logic             id_always,
    input  logic             id_annul,
    input  logic             ex_jmpl,
`ifdef IF_SEQ_PERF_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] annul_cnt,
    output logic [CNT_W-1:0] redir_cnt,
`endif
    output logic             pc_le,
    output logic             npc_le,
    output logic             ifid_le,
    output logic             ch_clear,
    output logic [1:0]       if_sel,
    output logic [1:0]       seq_state
);

    localparam int unsigned BOOT_W = 4;

    localparam logic [1:0] ST_BOOT  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_STALL = 2'b10;
    localparam logic [1:0] ST_JPEND = 2'b11;

    localparam logic [1:0] SEL_NPC = 2'b00;
    localparam logic [1:0] SEL_TA  = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    localparam logic [BOOT_W-1:0] BOOT_INIT = BOOT_W'(BOOT_CYCLES);

    if (BOOT_CYCLES < 1 || BOOT_CYCLES > 15 || CNT_W < 1) begin : g_param_chk
        $error("if_fetch_sequencer: BOOT_CYCLES must be 1..15 and CNT_W >= 1");
    end

    logic [1:0]        r_state;
    logic [BOOT_W-1:0] r_boot_cnt;
    logic              r_jpend;

    logic [1:0]        w_state_nxt;
    logic [BOOT_W-1:0] w_boot_nxt;
    logic              w_jpend_nxt;
    logic              w_le;
    logic              w_ch_clear;
    logic [1:0]        w_if_sel;

    // State, boot counter and deferred-JMPL flag
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_state    <= ST_BOOT;
            r_boot_cnt <= BOOT_INIT;
            r_jpend    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_boot_cnt <= w_boot_nxt;
            r_jpend    <= w_jpend_nxt;
        end
    end

    // Next state and combinational fetch controls
    always_comb begin
        w_state_nxt = r_state;
        w_boot_nxt  = r_boot_cnt;
        w_jpend_nxt = r_jpend;
        w_le        = 1'b0;
        w_ch_clear  = 1'b0;
        w_if_sel    = SEL_NPC;
        case (r_state)
            ST_BOOT: begin
                w_ch_clear = 1'b1;
                if (r_boot_cnt <= BOOT_W'(1)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_boot_nxt = r_boot_cnt - BOOT_W'(1);
                end
            end
            ST_RUN, ST_STALL: begin
                if (ex_jmpl && !hz_stall) begin
                    // delay slot of the JMPL executes; any ID branch is in its shadow
                    w_le        = 1'b1;
                    w_if_sel    = SEL_ALU;
                    w_state_nxt = ST_RUN;
                end else if (ex_jmpl) begin
                    w_jpend_nxt = 1'b1;
                    w_state_nxt = ST_JPEND;
                end else if (hz_stall) begin
                    w_state_nxt = ST_STALL;
                end else begin
                    w_le        = 1'b1;
                    w_state_nxt = ST_RUN;
                    if (id_branch) begin
                        if (id_cond_true) w_if_sel = SEL_TA;
                        w_ch_clear = id_annul && (!id_cond_true || id_always);
                    end
                end
            end
            ST_JPEND: begin
                if (!hz_stall) begin
                    w_le        = 1'b1;
                    if (r_jpend) w_if_sel = SEL_ALU;
                    w_jpend_nxt = 1'b0;
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    assign pc_le     = w_le;
    assign npc_le    = w_le;
    assign ifid_le   = w_le;
    assign ch_clear  = w_ch_clear;
    assign if_sel    = w_if_sel;
    assign seq_state = r_state;

`ifdef IF_SEQ_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_annul_cnt;
    logic [CNT_W-1:0] r_redir_cnt;
    logic             w_active;

    assign w_active = (r_state != ST_BOOT);

    // Saturating event counters; clear beats increment
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_stall_cnt <= '0;
            r_annul_cnt <= '0;
            r_redir_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
            r_annul_cnt <= '0;
            r_redir_cnt <= '0;
        end else begin
            if (w_active && hz_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_active && w_ch_clear && (r_annul_cnt != '1))
                r_annul_cnt <= r_annul_cnt + CNT_W'(1);
            if ((w_if_sel != SEL_NPC) && (r_redir_cnt != '1))
                r_redir_cnt <= r_redir_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign annul_cnt = r_annul_cnt;
    assign redir_cnt = r_redir_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_sequencer.sv
// Scoreboard bench for if_fetch_sequencer: the driver queues the expected per-cycle outputs,
// a negedge monitor pops and compares. Define IF_SEQ_PERF_EN to also exercise the counters.
module tb_if_fetch_sequencer;

    localparam logic [5:0] HZ = 6'b100000;
    localparam logic [5:0] BR = 6'b010000;
    localparam logic [5:0] CT = 6'b001000;
    localparam logic [5:0] AL = 6'b000100;
    localparam logic [5:0] AN = 6'b000010;
    localparam logic [5:0] JM = 6'b000001;
    localparam logic [5:0] NONE = 6'b000000;

    logic       clk = 1'b0;
    logic       R = 1'b0;
    logic       hz_stall = 1'b0, id_branch = 1'b0, id_cond_true = 1'b0;
    logic       id_always = 1'b0, id_annul = 1'b0, ex_jmpl = 1'b0;
    logic       pc_le, npc_le, ifid_le, ch_clear;
    logic [1:0] if_sel, seq_state;

    typedef struct {
        int         id;
        logic [7:0] outs;
        int         cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_id  = 0;

    always #5 clk = ~clk;

`ifdef IF_SEQ_PERF_EN
    logic       cnt_clr = 1'b0;
    logic [3:0] stall_cnt, annul_cnt, redir_cnt;

    if_fetch_sequencer #(.BOOT_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .R(R), .hz_stall(hz_stall), .id_branch(id_branch),
        .id_cond_true(id_cond_true), .id_always(id_always), .id_annul(id_annul),
        .ex_jmpl(ex_jmpl), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt),
        .annul_cnt(annul_cnt), .redir_cnt(redir_cnt),
        .pc_le(pc_le), .npc_le(npc_le), .ifid_le(ifid_le), .ch_clear(ch_clear),
        .if_sel(if_sel), .seq_state(seq_state));
`else
    if_fetch_sequencer #(.BOOT_CYCLES(2)) dut (
        .clk(clk), .R(R), .hz_stall(hz_stall), .id_branch(id_branch),
        .id_cond_true(id_cond_true), .id_always(id_always), .id_annul(id_annul),
        .ex_jmpl(ex_jmpl),
        .pc_le(pc_le), .npc_le(npc_le), .ifid_le(ifid_le), .ch_clear(ch_clear),
        .if_sel(if_sel), .seq_state(seq_state));
`endif

    // {seq_state, if_sel, ch_clear, pc_le, npc_le, ifid_le}
    function automatic logic [7:0] e(input logic [1:0] st, input logic [1:0] sel,
                                     input logic clr, input logic le);
        return {st, sel, clr, le, le, le};
    endfunction

    task automatic stepx(input logic r, input logic [5:0] in, input logic clr,
                         input logic mid_rst, input logic [7:0] exp_o, input int exp_cnt);
        exp_t x;
        @(posedge clk);
        #1;
        R = r;
        {hz_stall, id_branch, id_cond_true, id_always, id_annul, ex_jmpl} = in;
`ifdef IF_SEQ_PERF_EN
        cnt_clr = clr;
`else
        if (clr) $display("note: cnt_clr ignored in this build");
`endif
        x.id = n_id; x.outs = exp_o; x.cnt = exp_cnt;
        n_id++;
        q.push_back(x);
        if (mid_rst) begin
            #1;
            R = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic [5:0] in, input logic [7:0] exp_o);
        stepx(r, in, 1'b0, 1'b0, exp_o, -1);
    endtask

    // Monitor: compare whatever the driver queued for this cycle
    initial begin
        exp_t x;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                act = {seq_state, if_sel, ch_clear, pc_le, npc_le, ifid_le};
                n_cmp++;
                if (act !== x.outs) begin
                    n_bad++;
                    $display("FAIL outs#%0d got %b want %b", x.id, act, x.outs);
                end
`ifdef IF_SEQ_PERF_EN
                if (x.cnt >= 0) begin
                    n_cmp++;
                    if (stall_cnt !== 4'(x.cnt)) begin
                        n_bad++;
                        $display("FAIL stall_cnt#%0d got %0d want %0d", x.id, stall_cnt, x.cnt);
                    end
                end
`endif
            end
        end
    end

    initial begin
        // reset held
        repeat (3) step(1'b0, NONE, e(2'd0, 2'd0, 1'b1, 1'b0));
        // release: two boot cycles, inputs ignored
        step(1'b1, BR | CT | JM, e(2'd0, 2'd0, 1'b1, 1'b0));
        step(1'b1, HZ | JM, e(2'd0, 2'd0, 1'b1, 1'b0));
        step(1'b1, NONE, e(2'd1, 2'd0, 1'b0, 1'b1));
        // branches
        step(1'b1, BR | CT, e(2'd1, 2'd1, 1'b0, 1'b1));
        step(1'b1, BR | AN, e(2'd1, 2'd0, 1'b1, 1'b1));
        step(1'b1, BR | AL | AN | CT, e(2'd1, 2'd1, 1'b1, 1'b1));
        step(1'b1, BR | CT | AN, e(2'd1, 2'd1, 1'b0, 1'b1));
        step(1'b1, BR, e(2'd1, 2'd0, 1'b0, 1'b1));
        // stall with a taken branch waiting
        step(1'b1, HZ | BR | CT, e(2'd1, 2'd0, 1'b0, 1'b0));
        step(1'b1, HZ | BR | CT, e(2'd2, 2'd0, 1'b0, 1'b0));
        step(1'b1, HZ | BR | CT, e(2'd2, 2'd0, 1'b0, 1'b0));
        step(1'b1, BR | CT, e(2'd2, 2'd1, 1'b0, 1'b1));
        step(1'b1, NONE, e(2'd1, 2'd0, 1'b0, 1'b1));
        // JMPL in EX overrides a branch in ID
        step(1'b1, JM | BR | CT | AN, e(2'd1, 2'd2, 1'b0, 1'b1));
        // JMPL deferred across a stall
        step(1'b1, JM | HZ, e(2'd1, 2'd0, 1'b0, 1'b0));
        step(1'b1, HZ, e(2'd3, 2'd0, 1'b0, 1'b0));
        step(1'b1, HZ, e(2'd3, 2'd0, 1'b0, 1'b0));
        step(1'b1, NONE, e(2'd3, 2'd2, 1'b0, 1'b1));
        step(1'b1, NONE, e(2'd1, 2'd0, 1'b0, 1'b1));
        // JMPL arriving while already stalled
        step(1'b1, HZ, e(2'd1, 2'd0, 1'b0, 1'b0));
        step(1'b1, HZ | JM, e(2'd2, 2'd0, 1'b0, 1'b0));
        step(1'b1, NONE, e(2'd3, 2'd2, 1'b0, 1'b1));
        // JMPL on the stall-release cycle
        step(1'b1, HZ, e(2'd1, 2'd0, 1'b0, 1'b0));
        step(1'b1, JM, e(2'd2, 2'd2, 1'b0, 1'b1));
        step(1'b1, NONE, e(2'd1, 2'd0, 1'b0, 1'b1));
        // async reset in JPEND drops the pending redirect
        step(1'b1, JM | HZ, e(2'd1, 2'd0, 1'b0, 1'b0));
        step(1'b1, HZ, e(2'd3, 2'd0, 1'b0, 1'b0));
        stepx(1'b1, HZ, 1'b0, 1'b1, e(2'd0, 2'd0, 1'b1, 1'b0), -1);
        step(1'b1, NONE, e(2'd0, 2'd0, 1'b1, 1'b0));
        step(1'b1, NONE, e(2'd0, 2'd0, 1'b1, 1'b0));
        step(1'b1, NONE, e(2'd1, 2'd0, 1'b0, 1'b1));
        step(1'b1, NONE, e(2'd1, 2'd0, 1'b0, 1'b1));
`ifdef IF_SEQ_PERF_EN
        // saturation then clear-with-stall
        stepx(1'b1, NONE, 1'b1, 1'b0, e(2'd1, 2'd0, 1'b0, 1'b1), -1);
        step(1'b1, HZ, e(2'd1, 2'd0, 1'b0, 1'b0));
        repeat (19) step(1'b1, HZ, e(2'd2, 2'd0, 1'b0, 1'b0));
        stepx(1'b1, NONE, 1'b0, 1'b0, e(2'd2, 2'd0, 1'b0, 1'b1), 15);
        stepx(1'b1, HZ, 1'b1, 1'b0, e(2'd1, 2'd0, 1'b0, 1'b0), 15);
        stepx(1'b1, NONE, 1'b0, 1'b0, e(2'd2, 2'd0, 1'b0, 1'b1), 0);
`endif
        // drain the scoreboard within a bounded window
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
